// File: rtl/muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instruction_pkg
// Description : funct3 codes and MULDIV_7 funct7 value for OP multiply/divide
//               instructions, plus the muldiv_unit state encoding.
// Revision    : 1.0  initial release
// ============================================================================
package instruction_pkg;

    localparam logic [6:0] MULDIV_7  = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        DONE = 2'b11
    } muldiv_state_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_if
// Description : Request/response channels between the execution stage
//               (master) and the multiply/divide unit (slave).
// Revision    : 1.0  initial release
// ============================================================================
interface muldiv_if #(
    parameter int XLEN = 32
) ();
    logic            req_v_i;
    logic            req_ready_o;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic [4:0]      rd_i;
    logic            flush_i;
    logic            resp_v_o;
    logic            resp_ready_i;
    logic [XLEN-1:0] resp_data_o;
    logic [4:0]      resp_rd_o;

    modport master (
        output req_v_i, funct3_i, rs1_i, rs2_i, rd_i, flush_i, resp_ready_i,
        input  req_ready_o, resp_v_o, resp_data_o, resp_rd_o
    );

    modport slave (
        input  req_v_i, funct3_i, rs1_i, rs2_i, rd_i, flush_i, resp_ready_i,
        output req_ready_o, resp_v_o, resp_data_o, resp_rd_o
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit_iter.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_iter
// Description : Unsigned shift-add / restoring shift-subtract step datapath
//               with its 2*XLEN accumulator ({remainder, quotient} for divide).
// Revision    : 1.0  initial release
// ============================================================================
module muldiv_iter #(
    parameter int XLEN = 32
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              i_load,
    input  wire logic              i_step,
    input  wire logic              i_div,
    input  wire logic [XLEN-1:0]   i_a,
    input  wire logic [XLEN-1:0]   i_b,
    output logic      [2*XLEN-1:0] o_acc_next
);
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_b;
    logic              r_div;

    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_trial;
    logic [XLEN:0]     w_diff;
    logic [2*XLEN-1:0] w_mul_next;
    logic [2*XLEN-1:0] w_div_next;

    always_comb begin
        // Multiply: add multiplicand into the high half when the multiplier LSB is set, then shift right.
        w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_b};
        w_mul_next = r_acc[0] ? {w_sum, r_acc[XLEN-1:1]}
                              : {1'b0, r_acc[2*XLEN-1:1]};
        // Divide: partial remainder stays below the divisor, so the trial difference fits XLEN bits when positive.
        w_trial    = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
        w_diff     = w_trial - {1'b0, r_b};
        w_div_next = w_diff[XLEN] ? {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                  : {w_diff[XLEN-1:0],  r_acc[XLEN-2:0], 1'b1};
        o_acc_next = r_div ? w_div_next : w_mul_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc <= '0;
            r_b   <= '0;
            r_div <= 1'b0;
        end else if (i_load) begin
            r_acc <= {{XLEN{1'b0}}, i_a};
            r_b   <= i_b;
            r_div <= i_div;
        end else if (i_step) begin
            r_acc <= o_acc_next;
        end
    end
endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV M-extension multiply/divide unit with flush and
//               response backpressure. Define MULDIV_FAST_MUL_EN for a
//               single-cycle multiplier; divide stays iterative.
// Revision    : 1.0  initial release
// ============================================================================
module muldiv_unit
    import instruction_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  wire logic clk,
    input  wire logic reset,
    muldiv_if.slave   bus
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    muldiv_state_t     r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_neg;
    logic              r_sel_hi;
    logic              r_resp_v;
    logic [XLEN-1:0]   r_resp_data;
    logic [4:0]        r_rd;

    logic [2:0]        w_f3;
    logic              w_is_div, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg, w_neg, w_sel_hi;
    logic              w_b_zero, w_ovf, w_special, w_accept, w_step;
    logic [XLEN-1:0]   w_a_mag, w_b_mag, w_special_data;
    logic [2*XLEN-1:0] w_acc_next, w_mul_full;
    logic [XLEN-1:0]   w_div_sel, w_div_res, w_iter_res;

    assign w_f3     = bus.funct3_i;
    assign w_is_div = w_f3[2];
    assign w_a_sgn  = (w_f3 == F3_MULH) || (w_f3 == F3_MULHSU) || (w_f3 == F3_DIV) || (w_f3 == F3_REM);
    assign w_b_sgn  = (w_f3 == F3_MULH) || (w_f3 == F3_DIV) || (w_f3 == F3_REM);
    assign w_a_neg  = w_a_sgn & bus.rs1_i[XLEN-1];
    assign w_b_neg  = w_b_sgn & bus.rs2_i[XLEN-1];
    assign w_a_mag  = w_a_neg ? -bus.rs1_i : bus.rs1_i;
    assign w_b_mag  = w_b_neg ? -bus.rs2_i : bus.rs2_i;
    // Remainder follows the dividend's sign; everything else follows the sign product.
    assign w_neg    = (w_f3 == F3_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);
    assign w_sel_hi = w_is_div ? w_f3[1] : (w_f3[1:0] != 2'b00);

    assign w_b_zero       = (bus.rs2_i == '0);
    assign w_ovf          = w_is_div & w_b_sgn & (bus.rs1_i == {1'b1, {(XLEN-1){1'b0}}}) & (bus.rs2_i == '1);
    assign w_special      = w_is_div & (w_b_zero | w_ovf);
    assign w_special_data = w_b_zero ? (w_f3[1] ? bus.rs1_i : '1)
                                     : (w_f3[1] ? '0 : bus.rs1_i);

    assign w_accept = bus.req_v_i & (r_state == IDLE) & ~bus.flush_i;
    assign w_step   = (r_state == MUL) || (r_state == DIV);

    muldiv_iter #(.XLEN(XLEN)) u_iter (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_accept),
        .i_step     (w_step),
        .i_div      (w_is_div),
        .i_a        (w_a_mag),
        .i_b        (w_b_mag),
        .o_acc_next (w_acc_next)
    );

    assign w_mul_full = r_neg ? -w_acc_next : w_acc_next;
    assign w_div_sel  = r_sel_hi ? w_acc_next[2*XLEN-1:XLEN] : w_acc_next[XLEN-1:0];
    assign w_div_res  = r_neg ? -w_div_sel : w_div_sel;
    assign w_iter_res = (r_state == DIV) ? w_div_res
                      : (r_sel_hi ? w_mul_full[2*XLEN-1:XLEN] : w_mul_full[XLEN-1:0]);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fast_prod, w_fast_full;
    logic [XLEN-1:0]   w_fast_res;

    assign w_fast_prod = {{XLEN{1'b0}}, w_a_mag} * {{XLEN{1'b0}}, w_b_mag};
    assign w_fast_full = w_neg ? -w_fast_prod : w_fast_prod;
    assign w_fast_res  = w_sel_hi ? w_fast_full[2*XLEN-1:XLEN] : w_fast_full[XLEN-1:0];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_neg       <= 1'b0;
            r_sel_hi    <= 1'b0;
            r_resp_v    <= 1'b0;
            r_resp_data <= '0;
            r_rd        <= '0;
        end else if (bus.flush_i) begin
            r_state  <= IDLE;
            r_resp_v <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_v_i) begin
                        r_rd     <= bus.rd_i;
                        r_neg    <= w_neg;
                        r_sel_hi <= w_sel_hi;
                        r_cnt    <= CNT_W'(XLEN - 1);
                        if (w_special) begin
                            r_state     <= DONE;
                            r_resp_v    <= 1'b1;
                            r_resp_data <= w_special_data;
                        end else if (w_is_div) begin
                            r_state <= DIV;
                        end else begin
`ifdef MULDIV_FAST_MUL_EN
                            r_state     <= DONE;
                            r_resp_v    <= 1'b1;
                            r_resp_data <= w_fast_res;
`else
                            r_state <= MUL;
`endif
                        end
                    end
                end
                MUL, DIV: begin
                    // The last step's result is taken straight from the step logic.
                    if (r_cnt == '0) begin
                        r_state     <= DONE;
                        r_resp_v    <= 1'b1;
                        r_resp_data <= w_iter_res;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    if (bus.resp_ready_i) begin
                        r_state  <= IDLE;
                        r_resp_v <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready_o = (r_state == IDLE);
    assign bus.resp_v_o    = r_resp_v;
    assign bus.resp_data_o = r_resp_data;
    assign bus.resp_rd_o   = r_rd;
endmodule
`default_nettype wire
